uart_rx_buffered: RTL and testbench
===================================

// Module: uart_rx_buffered
// PURPOSE
//  UART 8N1 receiver with a first-word-fall-through (FWFT) receive FIFO.
//  - Samples the external UART_RX pin and assembles bytes.
//  - Presents bytes to the core (program/data loader) over a valid/ready handshake.
//  - Sits directly upstream of the core input path inside top_sub.
//  - Also reports framing and overrun errors.
// PARAMETERS
//  CLK_PER_BIT  259  CLK cycles per UART bit (>=4); half-bit point = CLK_PER_BIT/2, truncated
//  FIFO_AW      4    log2 of FIFO depth (depth = 2**FIFO_AW = 16)
// PORTS
//  CLK          in   1          system clock, all logic on rising edge
//  RST_N        in   1          async active-low reset
//  UART_RX      in   1          serial line, idle high, async to CLK
//  dout_ready   in   1          consumer accepts dout this cycle
//  dout_valid   out  1          FIFO non-empty; dout holds oldest byte
//  dout         out  8          head-of-FIFO byte
//  count        out  FIFO_AW+1  bytes currently held (0..2**FIFO_AW)
//  frame_err    out  1          one-cycle pulse: stop bit sampled low
//  overrun_err  out  1          sticky: byte dropped because FIFO full
//  err_clr      in   1          clears overrun_err
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; FIFO empty; dout_valid=0, dout=0, count=0.
//   - frame_err=0, overrun_err=0; both synchroniser flops=1.
//  Input sync: 2-flop synchroniser on UART_RX (rx_s); 2 cycles added latency.
//  FSM (bit counter bcnt 0..CLK_PER_BIT-1, bit index bidx 0..7):
//   - IDLE:  rx_s==0 -> START, bcnt=0.
//   - START: at bcnt==CLK_PER_BIT/2-1, sample rx_s.
//     - 0 -> DATA, bcnt=0, bidx=0.
//     - 1 -> IDLE (glitch rejected, no error).
//   - DATA:  at bcnt==CLK_PER_BIT-1, shift rx_s in at bit bidx (LSB first).
//     - After bidx==7 -> STOP.
//   - STOP:  at bcnt==CLK_PER_BIT-1, sample rx_s, then -> IDLE.
//     - 1: push byte.
//     - 0: frame_err=1 for exactly one cycle; byte discarded, no push.
//  FIFO: FWFT, registered write/read pointers with extra wrap bit.
//   - Push is registered: dout_valid/dout/count update the cycle after the STOP sample.
//   - Pop when dout_valid && dout_ready; next byte (if any) appears the following cycle.
//   - dout is stable while dout_valid=1 and dout_ready=0.
//   - Push and pop in the same cycle: both happen, count unchanged (includes full case).
//   - Push while full with no pop: byte dropped, FIFO untouched, overrun_err<=1.
//   - err_clr: overrun_err<=0; a simultaneous new overrun wins (stays 1).
//   - Pop while empty is ignored; pointers wrap modulo 2**FIFO_AW.
//  Reset mid-frame: partial byte discarded, FIFO contents lost; resumes in IDLE.
//  No parity; break condition (line held low) gives frame_err, then waits in IDLE
//   until rx_s goes high and falls again.
// TESTING (bench CLK_PER_BIT=16, FIFO_AW=2)
//  1. Send 0x55, then 0xA3, dout_ready=1:
//     -> dout 0x55 then 0xA3, one valid cycle each; count returns to 0; no errors.
//  2. 5-cycle low glitch on UART_RX:
//     -> FSM back to IDLE, dout_valid stays 0, frame_err never pulses.
//  3. Send 0x3C with stop bit forced 0:
//     -> frame_err one-cycle pulse, count=0, dout_valid=0.
//  4. Send 0x01..0x05, dout_ready=0:
//     -> count=4, overrun_err=1; drain gives 0x01..0x04;
//     -> err_clr clears overrun_err.
//  5. FIFO full, dout_ready=1 on the cycle 0x06 is pushed:
//     -> count stays 4, no overrun, 0x06 read last.
//  6. Assert RST_N=0 mid DATA bit 4, release, send 0x7E:
//     -> exactly one byte 0x7E received, no errors.

Source files
------------

// File: rtl/uart_rx_buffered.sv
// UART 8N1 receiver feeding a first-word-fall-through receive FIFO.
// Bytes are sampled mid-bit from a synchronised copy of the serial line.
// The FIFO head is presented on a valid/ready interface. A stop bit
// sampled low gives a one-cycle frame_err pulse. A byte that arrives
// while the FIFO is full sets the sticky overrun_err flag.
module uart_rx_buffered #(
    parameter int CLK_PER_BIT = 259,
    parameter int FIFO_AW     = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               UART_RX,
    input  logic               dout_ready,
    output logic               dout_valid,
    output logic [7:0]         dout,
    output logic [FIFO_AW:0]   count,
    output logic               frame_err,
    output logic               overrun_err,
    input  logic               err_clr
);
    localparam int BCW   = $clog2(CLK_PER_BIT);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [BCW-1:0] HALF_M1 = BCW'(CLK_PER_BIT / 2 - 1);
    localparam logic [BCW-1:0] LAST    = BCW'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_q, state_d;
    logic [BCW-1:0]      bcnt_q, bcnt_d;
    logic [2:0]          bidx_q, bidx_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                rx_meta_q, rx_s_q, rx_prev_q;
    logic                ferr_q, ferr_d;
    logic                push;

    logic [FIFO_AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]          dout_q, dout_d;
    logic                overrun_q, overrun_d;
    logic                fifo_empty, fifo_full, pop, wr_en;
    logic [7:0]          mem [DEPTH];

    // Receive FSM: falling-edge start detect, half-bit start check, 8 data bits, stop bit.
    // Requiring rx_prev high keeps a held-low line (break) from restarting a frame.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        ferr_d  = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                bcnt_d = '0;
                if (!rx_s_q && rx_prev_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (bcnt_q == HALF_M1) begin
                    bcnt_d  = '0;
                    bidx_d  = 3'd0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    bcnt_d = bcnt_q + BCW'(1);
                end
            end
            DATA: begin
                if (bcnt_q == LAST) begin
                    bcnt_d          = '0;
                    shreg_d[bidx_q] = rx_s_q;
                    if (bidx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q + BCW'(1);
                end
            end
            STOP: begin
                if (bcnt_q == LAST) begin
                    bcnt_d  = '0;
                    state_d = IDLE;
                    if (rx_s_q) begin
                        push = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    bcnt_d = bcnt_q + BCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO control: pointers carry a wrap bit so full and empty are distinguishable.
    // dout is kept in a register holding the next head so it never changes mid-hold.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        pop        = !fifo_empty && dout_ready;
        wr_en      = push && (!fifo_full || pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        dout_d     = dout_q;
        if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
            dout_d = shreg_q;
        end else if (rd_ptr_d != wr_ptr_q) begin
            dout_d = mem[rd_ptr_d[FIFO_AW-1:0]];
        end
        overrun_d = overrun_q;
        if (push && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end
    end

    // State, synchroniser, pointer and flag registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            bidx_q    <= 3'd0;
            shreg_q   <= 8'h00;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            ferr_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            dout_q    <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            bidx_q    <= bidx_d;
            shreg_q   <= shreg_d;
            rx_meta_q <= UART_RX;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            ferr_q    <= ferr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            dout_q    <= dout_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr_q[FIFO_AW-1:0]] <= shreg_q;
        end
    end

    assign dout_valid  = !fifo_empty;
    assign dout        = dout_q;
    assign count       = wr_ptr_q - rd_ptr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = overrun_q;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: directed scenarios plus random
// traffic, compared every cycle against a queue-based model of the receiver.
module tb_uart_rx_buffered;
    localparam int CPB      = 16;
    localparam int AW       = 2;
    localparam int DEPTH    = 4;
    localparam int PUSH_CYC = 2 + CPB / 2 + 9 * CPB;

    logic        CLK, RST_N, UART_RX, dout_ready, err_clr;
    logic        dout_valid, frame_err, overrun_err;
    logic [7:0]  dout;
    logic [AW:0] count;

    uart_rx_buffered #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .UART_RX(UART_RX), .dout_ready(dout_ready),
        .dout_valid(dout_valid), .dout(dout), .count(count),
        .frame_err(frame_err), .overrun_err(overrun_err), .err_clr(err_clr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    logic [7:0] q[$];
    bit   exp_ovr = 0, exp_ferr = 0, mon_en = 0, rand_ready = 0;
    int   hs_cnt = 0, ferr_cnt = 0;
    logic [7:0] last_pop = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, then model pop on handshake.
    always @(negedge CLK) begin
        if (mon_en && RST_N) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("valid", 32'(dout_valid), 32'(q.size() > 0));
            if (q.size() > 0) chk("dout", 32'(dout), 32'(q[0]));
            chk("overrun", 32'(overrun_err), 32'(exp_ovr));
            chk("frame_err", 32'(frame_err), 32'(exp_ferr));
            if (dout_valid && dout_ready) begin
                hs_cnt++;
                last_pop = dout;
            end
            if (frame_err) ferr_cnt++;
            if (q.size() > 0 && dout_ready) void'(q.pop_front());
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (rand_ready) dout_ready = ($urandom_range(0, 2) == 0);
        end
    end

    // One serial frame; pulse bit0 = ready pulse, bit1 = err_clr pulse on the push cycle.
    task automatic send(input logic [7:0] data, input bit stop, input int extra_low,
                        input int pulse, input int abort_at);
        int nbits;
        int b;
        logic v;
        nbits = 10 + extra_low;
        for (int c = 0; c < nbits * CPB; c++) begin
            @(posedge CLK);
            #1;
            if (c == abort_at) begin
                UART_RX = 1'b1;
                RST_N   = 1'b0;
                q.delete();
                exp_ovr  = 0;
                exp_ferr = 0;
                repeat (3) @(posedge CLK);
                #1;
                RST_N = 1'b1;
                return;
            end
            b = c / CPB;
            if (b == 0)      v = 1'b0;
            else if (b <= 8) v = data[b-1];
            else if (b == 9) v = stop;
            else             v = 1'b0;
            UART_RX = v;
            if (c == PUSH_CYC) begin
                if (pulse[0]) dout_ready = 1'b1;
                if (pulse[1]) err_clr = 1'b1;
            end
            if (c == PUSH_CYC + 1) begin
                if (pulse[0]) dout_ready = 1'b0;
                if (pulse[1]) begin
                    err_clr = 1'b0;
                    exp_ovr = 0;
                end
                if (stop) begin
                    if (q.size() < DEPTH) q.push_back(data);
                    else exp_ovr = 1;
                end else begin
                    exp_ferr = 1;
                end
            end
            if (c == PUSH_CYC + 2) exp_ferr = 0;
        end
        @(posedge CLK);
        #1;
        UART_RX = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_err();
        @(posedge CLK);
        #1;
        err_clr = 1'b1;
        @(posedge CLK);
        #1;
        err_clr = 1'b0;
        exp_ovr = 0;
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        idle(DEPTH * 3);
    endtask

    int h0, f0;
    logic [7:0] rb;

    initial begin
        RST_N = 1'b0; UART_RX = 1'b1; dout_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_ovr", 32'(overrun_err), 0);
        @(posedge CLK);
        #1;
        RST_N  = 1'b1;
        mon_en = 1;
        idle(5);

        // Two clean bytes with the consumer always ready
        h0 = hs_cnt; f0 = ferr_cnt;
        dout_ready = 1'b1;
        send(8'h55, 1, 0, 0, -1);
        send(8'hA3, 1, 0, 0, -1);
        idle(20);
        chk("t1_hs", 32'(hs_cnt - h0), 2);
        chk("t1_last", 32'(last_pop), 32'h A3);
        chk("t1_count", 32'(count), 0);
        chk("t1_ferr", 32'(ferr_cnt - f0), 0);

        // Short low glitch must be rejected silently
        h0 = hs_cnt; f0 = ferr_cnt;
        UART_RX = 1'b0;
        idle(5);
        UART_RX = 1'b1;
        idle(40);
        chk("t2_hs", 32'(hs_cnt - h0), 0);
        chk("t2_ferr", 32'(ferr_cnt - f0), 0);

        // Framing error
        h0 = hs_cnt; f0 = ferr_cnt;
        send(8'h3C, 0, 0, 0, -1);
        idle(20);
        chk("t3_ferr", 32'(ferr_cnt - f0), 1);
        chk("t3_hs", 32'(hs_cnt - h0), 0);

        // Overrun with consumer stalled, then drain and clear
        dout_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(i), 1, 0, 0, -1);
        idle(5);
        chk("t4_count", 32'(count), 4);
        chk("t4_ovr", 32'(overrun_err), 1);
        h0 = hs_cnt;
        drain();
        chk("t4_hs", 32'(hs_cnt - h0), 4);
        chk("t4_last", 32'(last_pop), 32'h04);
        clear_err();
        idle(2);
        chk("t4_clr", 32'(overrun_err), 0);

        // Full FIFO with a pop on the exact push cycle
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'($urandom), 1, 0, 0, -1);
        send(8'h06, 1, 0, 1, -1);
        idle(5);
        chk("t5_count", 32'(count), 4);
        chk("t5_ovr", 32'(overrun_err), 0);
        drain();
        chk("t5_last", 32'(last_pop), 32'h06);

        // Overrun coinciding with err_clr keeps the flag set
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'($urandom), 1, 0, 0, -1);
        send(8'hEE, 1, 0, 2, -1);
        idle(3);
        chk("t7_ovr", 32'(overrun_err), 1);
        drain();
        clear_err();

        // Reset mid-frame, then a clean byte
        dout_ready = 1'b0;
        send(8'h11, 1, 0, 0, -1);
        send(8'h22, 1, 0, 0, 5 * CPB + CPB / 2);
        idle(2);
        chk("t6_count", 32'(count), 0);
        idle(20);
        h0 = hs_cnt; f0 = ferr_cnt;
        dout_ready = 1'b1;
        send(8'h7E, 1, 0, 0, -1);
        idle(20);
        chk("t6_hs", 32'(hs_cnt - h0), 1);
        chk("t6_last", 32'(last_pop), 32'h7E);
        chk("t6_ferr", 32'(ferr_cnt - f0), 0);

        // Break: line held low past the stop bit, then a normal byte
        h0 = hs_cnt; f0 = ferr_cnt;
        send(8'h00, 0, 3, 0, -1);
        idle(10);
        rb = 8'($urandom);
        send(rb, 1, 0, 0, -1);
        idle(20);
        chk("brk_ferr", 32'(ferr_cnt - f0), 1);
        chk("brk_hs", 32'(hs_cnt - h0), 1);
        chk("brk_last", 32'(last_pop), 32'(rb));

        // Random traffic against the model
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), ($urandom_range(0, 7) != 0), 0,
                 ($urandom_range(0, 5) == 0) ? 2 : 0, -1);
            idle($urandom_range(4, 30));
            if ($urandom_range(0, 4) == 0) clear_err();
        end
        rand_ready = 0;
        @(posedge CLK);
        #3;
        dout_ready = 1'b1;
        idle(20);
        chk("end_count", 32'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
